// File: rtl/channel_word_serializer.sv
// channel_word_serializer
// Takes one CHANNEL x WIDTH frame per handshake and streams it out as
// CHANNEL data beats (highest channel first), followed by one XOR checksum beat.
// The beats are sent in this order so that a shift-in deserializer, which
// shifts each new word into its low slice, ends up with channel 0 in the low bits.
//
// Handshake rules, for both ports: a transfer happens on a rising clk edge
// where valid && ready. Once out_valid is high, it stays high, and
// out_data/out_chan/out_last stay unchanged, until the edge where out_ready
// completes the transfer. in_data is sampled only on the accept edge.
//
// dbg_state shows the FSM state: 0 = IDLE, 1 = SEND, 2 = CSUM.
module channel_word_serializer #(
  parameter int WIDTH   = 32,
  parameter int CHANNEL = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNEL*WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [2:0]                 out_chan,
  output logic                       out_last,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX  = 3'(CHANNEL - 1);
  localparam logic [2:0] CSUM_CHAN = 3'(CHANNEL);

  state_t                     state_q, state_d;
  logic [2:0]                 idx_q, idx_d;
  logic [CHANNEL*WIDTH-1:0]   buf_q, buf_d;
  logic [WIDTH-1:0]           csum_q, csum_d;

  logic [WIDTH-1:0]           csum_in;
  logic [WIDTH-1:0]           beat_word;
  logic                       accept;

  // XOR of all channel words of the frame being offered at the input
  always_comb begin
    csum_in = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      csum_in = csum_in ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  // Select the buffered channel word addressed by the beat index
  always_comb begin
    beat_word = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      if (idx_q == 3'(k)) begin
        beat_word = buf_q[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and output logic; a frame accept has priority over a CSUM->IDLE return
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    csum_d    = csum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_chan  = '0;
    out_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = beat_word;
        out_chan  = idx_q;
        if (out_ready) begin
          if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
          end else begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_chan  = CSUM_CHAN;
        out_last  = 1'b1;
        // The next frame may only enter on the edge where the checksum beat leaves
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    accept = in_valid && in_ready;
    if (accept) begin
      buf_d   = in_data;
      csum_d  = csum_in;
      idx_d   = LAST_IDX;
      state_d = ST_SEND;
    end
  end

  // State, index, frame buffer and checksum registers; async reset drops any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      csum_q  <= csum_d;
    end
  end

  // Expose the FSM state for checkers
  assign dbg_state = state_q;

endmodule

// File: tb/tb_channel_word_serializer.sv
// Bench for channel_word_serializer (WIDTH=32, CHANNEL=5).
// The reference model works at frame level. Each accepted frame is turned
// into its expected beat list (channels high to low, then the XOR), and the
// beat list is queued. The queue is then enough to predict in_ready and
// out_valid on every cycle.
module tb_channel_word_serializer;
  localparam int W  = 32;
  localparam int CH = 5;
  localparam int FW = CH * W;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [FW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_chan;
  logic           out_last;
  logic [1:0]     dbg_state;

  channel_word_serializer #(.WIDTH(W), .CHANNEL(CH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: beat = {data, chan, last}
  logic [W+3:0]   exp_q[$];
  logic [FW-1:0]  sent_q[$];
  logic [FW-1:0]  shift_reg;
  logic           held_v;
  logic [W+3:0]   held_beat;
  logic [W-1:0]   last_csum_seen;
  int             beats_seen;
  int             acc_cnt;
  int             total;
  int             bad;

  typedef struct {
    logic [FW-1:0] frame;
    logic [W-1:0]  exp_csum;
    logic [W-1:0]  exp_first;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s: cycle budget expired", name);
  endtask

  // model: expand a frame into its expected beats
  task automatic model_push(input logic [FW-1:0] fr);
    logic [W-1:0] cs;
    cs = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      exp_q.push_back({fr[k*W +: W], 3'(k), 1'b0});
      cs = cs ^ fr[k*W +: W];
    end
    exp_q.push_back({cs, 3'(CH), 1'b1});
    sent_q.push_back(fr);
  endtask

  // per-cycle checks, sampled at the falling edge
  task automatic monitor();
    logic exp_rdy;
    logic [FW-1:0] fr;
    if (rst) return;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    check("in_ready", FW'(in_ready), FW'(exp_rdy));
    check("out_valid", FW'(out_valid), FW'(exp_q.size() != 0));
    if (held_v) begin
      check("stable", FW'({out_data, out_chan, out_last}), FW'(held_beat));
    end
    held_v = 1'b0;
    if (out_valid && exp_q.size() > 0) begin
      check("beat", FW'({out_data, out_chan, out_last}), FW'(exp_q[0]));
      if (out_ready) begin
        void'(exp_q.pop_front());
        beats_seen++;
        if (out_last) begin
          last_csum_seen = out_data;
          fr = sent_q.pop_front();
          check("roundtrip", shift_reg, fr);
        end else begin
          shift_reg = {shift_reg[FW-W-1:0], out_data};
        end
      end else begin
        held_v    = 1'b1;
        held_beat = {out_data, out_chan, out_last};
      end
    end
    if (in_valid && in_ready) begin
      acc_cnt++;
      model_push(in_data);
    end
  endtask

  // driver: one clock cycle; inputs are changed by callers at posedge+1
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) timeout(name);
    step();
  endtask

  task automatic send_frame(input logic [FW-1:0] fr);
    in_valid = 1'b1;
    in_data  = fr;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_chan(input logic [2:0] ch, input string name);
    int n;
    n = 0;
    while (!(out_valid && out_chan == ch) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) timeout(name);
  endtask

  logic [FW-1:0] f_ramp, f_a, f_b, f_ones, f_all1;
  int            b0, cyc, n;
  logic [FW-1:0] rnd;

  initial begin
    total = 0; bad = 0; beats_seen = 0; acc_cnt = 0;
    held_v = 1'b0; shift_reg = '0; last_csum_seen = '0;
    f_ramp = {32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    f_a    = {5{32'hFFFF_0000}};
    f_b    = {32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    f_ones = {5{32'h1}};
    f_all1 = '1;
    // XOR values worked out by hand: 5^4^3^2^1=1, odd copies of FFFF0000, A^B^C^D^E=E, 1^1^1^1^1=1
    vecs[0] = '{frame: f_ramp, exp_csum: 32'h1,         exp_first: 32'h5};
    vecs[1] = '{frame: f_a,    exp_csum: 32'hFFFF_0000, exp_first: 32'hFFFF_0000};
    vecs[2] = '{frame: f_b,    exp_csum: 32'hE,         exp_first: 32'hA};
    vecs[3] = '{frame: f_ones, exp_csum: 32'h1,         exp_first: 32'h1};

    rst = 1'b1; in_valid = 1'b1; in_data = f_ramp; out_ready = 1'b1;
    step(); step();
    // reset values; the handshake offered during reset must be dropped
    check("rst_in_ready", FW'(in_ready), FW'(1'b1));
    check("rst_out_valid", FW'(out_valid), '0);
    check("rst_out_data", FW'(out_data), '0);
    check("rst_out_chan", FW'(out_chan), '0);
    check("rst_out_last", FW'(out_last), '0);
    check("rst_state", FW'(dbg_state), '0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();

    // table-driven single frames
    for (int i = 0; i < 4; i++) begin
      b0 = beats_seen;
      send_frame(vecs[i].frame);
      check("latency_valid", FW'(out_valid), FW'(1'b1));
      check("first_beat", FW'({out_data, out_chan}), FW'({vecs[i].exp_first, 3'(CH - 1)}));
      drain("table");
      check("tbl_csum", FW'(last_csum_seen), FW'(vecs[i].exp_csum));
      check("tbl_beats", FW'(beats_seen - b0), FW'(6));
    end

    // backpressure during the channel-2 beat
    b0 = beats_seen;
    send_frame(f_ramp);
    wait_chan(3'd2, "bp");
    out_ready = 1'b0;
    step(); step(); step();
    check("bp_hold", FW'({out_data, out_chan}), FW'({32'h3, 3'd2}));
    out_ready = 1'b1;
    drain("bp");
    check("bp_beats", FW'(beats_seen - b0), FW'(6));

    // back-to-back frames A then B, with in_valid held high
    b0 = beats_seen;
    acc_cnt = 0;
    in_valid = 1'b1;
    in_data = f_a;
    step();
    in_data = f_b;
    cyc = 0;
    while (acc_cnt < 2 && cyc < 20) begin
      step();
      cyc++;
    end
    in_valid = 1'b0;
    while (exp_q.size() != 0 && cyc < 40) begin
      step();
      cyc++;
    end
    check("b2b_cycles", FW'(cyc), FW'(12));
    check("b2b_beats", FW'(beats_seen - b0), FW'(12));
    check("b2b_csum_b", FW'(last_csum_seen), FW'(32'hE));
    step();

    // in_data changes after accept must not affect the frame in flight
    send_frame(f_ramp);
    in_data = f_all1;
    drain("chg");
    check("chg_csum", FW'(last_csum_seen), FW'(32'h1));

    // asynchronous reset in the middle of the channel-2 beat
    send_frame(f_ramp);
    wait_chan(3'd2, "rst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", FW'(out_valid), '0);
    check("arst_out_data", FW'(out_data), '0);
    check("arst_out_chan", FW'(out_chan), '0);
    check("arst_out_last", FW'(out_last), '0);
    check("arst_in_ready", FW'(in_ready), FW'(1'b1));
    exp_q.delete();
    sent_q.delete();
    held_v = 1'b0;
    shift_reg = '0;
    step();
    rst = 1'b0;
    step();
    send_frame(f_ones);
    drain("post_rst");
    check("post_rst_csum", FW'(last_csum_seen), FW'(32'h1));

    // random frames with random valid and backpressure
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 100 && n < 5000) begin
      if (!in_valid || in_ready) begin
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (in_valid && !in_ready) begin
        in_valid = 1'b1;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rnd;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      n++;
    end
    if (acc_cnt < 100) timeout("random");
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
